// File: rtl/keypad_if.sv
// ---------------------------------------------------------------------------
// keypad_if
//   Signal bundle between the 4x4 keypad scanner and the keypad matrix /
//   display consumer.
//   row_in    : keypad rows, active low, asynchronous to the scanner clock
//   col_out   : keypad column drive, active low, one-hot-zero
//   key_code  : code of the last accepted key (row*4 + col)
//   key_valid : one-cycle pulse when a press is accepted
//   key_down  : high from accepted press until accepted release
//   Modports: master = scanner side, slave = keypad / consumer side.
// ---------------------------------------------------------------------------
interface keypad_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   modport master (
      input  row_in,
      output col_out,
      output key_code,
      output key_valid,
      output key_down
   );

   modport slave (
      output row_in,
      input  col_out,
      input  key_code,
      input  key_valid,
      input  key_down
   );
endinterface

// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan
//   4x4 matrix keypad scanner. Drives one column low at a time, samples the
//   rows through a 2-flop synchroniser, debounces press and release, and
//   reports the hex code of the pressed key for the 7-segment display path.
//
//   Parameters
//     SCAN_DIV          clk cycles per column step (>= 4)
//     DEBOUNCE_SAMPLES  consecutive agreeing sample ticks to accept a
//                       press or a release (>= 1)
//   Ports
//     clk  : system clock, rising edge
//     rst  : synchronous, active-high reset
//     kp   : keypad_if.master (row_in in; col_out, key_code, key_valid,
//            key_down out; all outputs registered)
// ---------------------------------------------------------------------------
module keypad_scan #(
   parameter int SCAN_DIV         = 50000,
   parameter int DEBOUNCE_SAMPLES = 16
) (
   input  logic     clk,
   input  logic     rst,
   keypad_if.master kp
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_SAMPLES + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_SAMPLES);
   localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Registers and their next-state values
   // ------------------------------------------------------------------
   logic [3:0]       sync1;
   logic [3:0]       rs;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   state_t           state,       state_nx;
   logic [1:0]       col_idx,     col_idx_nx;
   logic [DEB_W-1:0] deb_cnt,     deb_cnt_nx;
   logic [3:0]       cand,        cand_nx;
   logic [3:0]       pat,         pat_nx;
   logic [3:0]       col_out_q;
   logic [3:0]       key_code_q,  key_code_nx;
   logic             key_valid_q, key_valid_nx;
   logic             key_down_q,  key_down_nx;

   logic             single;
   logic [1:0]       row_sel;
   logic [DEB_W-1:0] deb_inc;

   // ------------------------------------------------------------------
   // Row synchroniser and column-step divider
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 4'hF;
         rs      <= 4'hF;
         div_cnt <= '0;
      end else begin
         sync1   <= kp.row_in;
         rs      <= sync1;
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   // Exactly one row low -> a candidate key in the driven column.
   always_comb begin
      single  = 1'b1;
      row_sel = 2'd0;
      case (rs)
         4'b1110: row_sel = 2'd0;
         4'b1101: row_sel = 2'd1;
         4'b1011: row_sel = 2'd2;
         4'b0111: row_sel = 2'd3;
         default: single  = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   // NOTE: only control/datapath registers are reset; there is no memory
   // array here, so every flop gets a defined reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SCAN;
         col_idx     <= 2'd0;
         deb_cnt     <= '0;
         cand        <= 4'h0;
         pat         <= 4'hF;
         col_out_q   <= 4'b1110;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         state       <= state_nx;
         col_idx     <= col_idx_nx;
         deb_cnt     <= deb_cnt_nx;
         cand        <= cand_nx;
         pat         <= pat_nx;
         // Column drive is decoded from the next index so col_out is a flop.
         col_out_q   <= ~(4'b0001 << col_idx_nx);
         key_code_q  <= key_code_nx;
         key_valid_q <= key_valid_nx;
         key_down_q  <= key_down_nx;
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first, so no
      // path through the case/if tree can infer a latch.
      state_nx     = state;
      col_idx_nx   = col_idx;
      deb_cnt_nx   = deb_cnt;
      cand_nx      = cand;
      pat_nx       = pat;
      key_code_nx  = key_code_q;
      key_valid_nx = 1'b0;         // pulse is always exactly one clk wide
      key_down_nx  = key_down_q;
      deb_inc      = deb_cnt + DEB_ONE;

      if (tick) begin
         case (state)
            SCAN: begin
               if (single) begin
                  cand_nx = {row_sel, col_idx};
                  pat_nx  = rs;
                  if (DEB_DONE == DEB_ONE) begin
                     // One agreeing sample is enough: accept immediately.
                     key_code_nx  = {row_sel, col_idx};
                     key_valid_nx = 1'b1;
                     key_down_nx  = 1'b1;
                     deb_cnt_nx   = '0;
                     state_nx     = HELD;
                  end else begin
                     deb_cnt_nx = DEB_ONE;
                     state_nx   = DEBOUNCE;
                  end
               end else begin
                  col_idx_nx = col_idx + 2'd1;
               end
            end

            DEBOUNCE: begin
               if (rs == pat) begin
                  if (deb_inc == DEB_DONE) begin
                     key_code_nx  = cand;
                     key_valid_nx = 1'b1;
                     key_down_nx  = 1'b1;
                     deb_cnt_nx   = '0;
                     state_nx     = HELD;
                  end else begin
                     deb_cnt_nx = deb_inc;
                  end
               end else begin
                  // Bounce or glitch: abandon the candidate silently.
                  deb_cnt_nx = '0;
                  col_idx_nx = col_idx + 2'd1;
                  state_nx   = SCAN;
               end
            end

            HELD: begin
               // Release needs all rows high; any low row (bounce or a
               // second key) restarts the release count.
               if (rs == 4'hF) begin
                  if (deb_inc == DEB_DONE) begin
                     key_down_nx = 1'b0;
                     deb_cnt_nx  = '0;
                     col_idx_nx  = col_idx + 2'd1;
                     state_nx    = SCAN;
                  end else begin
                     deb_cnt_nx = deb_inc;
                  end
               end else begin
                  deb_cnt_nx = '0;
               end
            end

            default: begin
               deb_cnt_nx = '0;
               state_nx   = SCAN;
            end
         endcase
      end
   end

   assign kp.col_out   = col_out_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan
//   Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SAMPLES=3.
//   A small keypad model pulls row r low when key(r,c) is pressed and
//   column c is driven low. Outputs are sampled on the falling clock edge;
//   comments give the falling-edge index counted from reset release.
// ---------------------------------------------------------------------------
module tb_keypad_scan;

   logic        clk;
   logic        rst;
   logic [15:0] keys;       // bit r*4+c = key(r,c) pressed
   logic [3:0]  row_model;
   int          n_checks;
   int          n_errors;
   int          pulse_cnt;

   keypad_if kp ();

   keypad_scan #(
      .SCAN_DIV         (4),
      .DEBOUNCE_SAMPLES (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix model.
   always_comb begin
      row_model = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !kp.col_out[c]) row_model[r] = 1'b0;
         end
      end
   end
   assign kp.row_in = row_model;

   // Count clk cycles with key_valid high; a wide pulse counts more than once.
   always @(posedge clk) begin
      if (kp.key_valid) pulse_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      pulse_cnt = 0;
      keys      = 16'h0000;
      rst       = 1'b1;

      // ---- 1: reset for 2 clk, then column stepping -------------------
      nclk(2);
      check("rst_col",   kp.col_out,   4'b1110);
      check("rst_valid", kp.key_valid, 1'b0);
      check("rst_down",  kp.key_down,  1'b0);
      check("rst_code",  kp.key_code,  4'h0);
      rst = 1'b0;                                   // edge 0
      nclk(2);  check("scan_c0_mid", kp.col_out, 4'b1110);   // 2
      nclk(2);  check("scan_c1",     kp.col_out, 4'b1101);   // 4
      nclk(4);  check("scan_c2",     kp.col_out, 4'b1011);   // 8
      nclk(4);  check("scan_c3",     kp.col_out, 4'b0111);   // 12
      nclk(4);  check("scan_wrap",   kp.col_out, 4'b1110);   // 16

      // ---- 2: hold key(2,1) -------------------------------------------
      keys = 16'h0200;
      nclk(16);                                     // 32
      check("hold_valid_rise", kp.key_valid, 1'b1);
      check("hold_code",       kp.key_code,  4'h9);
      check("hold_down",       kp.key_down,  1'b1);
      nclk(1);                                      // 33
      check("hold_valid_fall", kp.key_valid, 1'b0);
      nclk(40);                                     // 73
      check("hold_pulses", pulse_cnt,   1);
      check("hold_col",    kp.col_out,  4'b1101);
      check("hold_down2",  kp.key_down, 1'b1);

      // ---- 4: release with one bounce ---------------------------------
      keys = 16'h0000;                              // 73: high
      nclk(4);
      keys = 16'h0200;                              // 77: bounce low
      check("bounce_down_a", kp.key_down, 1'b1);
      nclk(4);
      keys = 16'h0000;                              // 81: high for good
      check("bounce_down_b", kp.key_down, 1'b1);
      nclk(10);                                     // 91
      check("rel_down_hold", kp.key_down, 1'b1);
      check("rel_col_hold",  kp.col_out,  4'b1101);
      nclk(1);                                      // 92
      check("rel_down_fall", kp.key_down, 1'b0);
      check("rel_col_step",  kp.col_out,  4'b1011);

      // ---- 3: short press of key(1,3) ---------------------------------
      nclk(1);
      keys = 16'h0080;                              // 93
      nclk(8);                                      // 101
      check("short_col_frozen", kp.col_out, 4'b0111);
      keys = 16'h0000;
      nclk(3);                                      // 104
      check("short_col_resume", kp.col_out,  4'b1110);
      check("short_pulses",     pulse_cnt,   1);
      check("short_code",       kp.key_code, 4'h9);
      check("short_down",       kp.key_down, 1'b0);

      // ---- 5a: two keys in the same column ----------------------------
      keys = 16'h4004;                              // key(0,2) + key(3,2)
      nclk(14);                                     // 118
      check("dual_col_past", kp.col_out, 4'b0111);
      nclk(18);                                     // 136
      check("dual_col_wrap", kp.col_out,  4'b1110);
      check("dual_pulses",   pulse_cnt,   1);
      check("dual_down",     kp.key_down, 1'b0);

      // ---- 5b: key(3,3) then add key(0,0) while held ------------------
      keys = 16'h8000;
      nclk(24);                                     // 160
      check("k33_valid", kp.key_valid, 1'b1);
      check("k33_code",  kp.key_code,  4'hF);
      nclk(5);
      keys = 16'h8001;                              // 165
      nclk(35);                                     // 200
      check("k33_pulses", pulse_cnt,   2);
      check("k33_code2",  kp.key_code, 4'hF);
      check("k33_down",   kp.key_down, 1'b1);
      check("k33_col",    kp.col_out,  4'b0111);

      // ---- 6: reset while HELD, key still pressed ---------------------
      keys = 16'h8000;
      rst  = 1'b1;                                  // 200
      nclk(1);                                      // 201
      check("mid_rst_col",   kp.col_out,   4'b1110);
      check("mid_rst_code",  kp.key_code,  4'h0);
      check("mid_rst_valid", kp.key_valid, 1'b0);
      check("mid_rst_down",  kp.key_down,  1'b0);
      rst = 1'b0;                                   // new edge 0
      nclk(24);
      check("redet_valid", kp.key_valid, 1'b1);
      check("redet_code",  kp.key_code,  4'hF);
      check("redet_down",  kp.key_down,  1'b1);
      check("redet_col",   kp.col_out,   4'b0111);
      nclk(15);
      check("redet_pulses", pulse_cnt,   3);
      check("redet_quiet",  kp.key_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
